issue_rename_stage: RTL

//  Issue/rename stage in front of the reservation-station units (ALU, mul, div, ls).

---
 rtl/tomasulo_pkg.sv | 45 ++++
 rtl/reg_status_file.sv | 57 +++++
 rtl/issue_rename_stage.sv | 125 ++++++++++++
 3 files changed

// File: rtl/tomasulo_pkg.sv
// Shared types, CDB field layout and unit ids for the Tomasulo front end.
// cdb_hit: live CDB broadcast matches a non-zero (waiting) tag.
package tomasulo_pkg;

  localparam int XLEN  = 32;
  localparam int TAGW  = 8;
  localparam int NREGS = 32;
  localparam int CDBW  = 1 + TAGW + XLEN;

  localparam int CDB_VALID  = 40;
  localparam int CDB_TAG_HI = 39;
  localparam int CDB_TAG_LO = 32;
  localparam int CDB_VAL_HI = 31;
  localparam int CDB_VAL_LO = 0;

  localparam logic [1:0] UNIT_ALU = 2'd0;
  localparam logic [1:0] UNIT_MUL = 2'd1;
  localparam logic [1:0] UNIT_DIV = 2'd2;
  localparam logic [1:0] UNIT_LS  = 2'd3;

  typedef logic [TAGW-1:0] tag_t;
  typedef logic [XLEN-1:0] val_t;

  typedef struct packed {
    tag_t q1;
    val_t v1;
    tag_t q2;
    val_t v2;
  } opnd_t;

  function automatic logic cdb_hit(
    input logic [CDBW-1:0] cdb,
    input tag_t            tag
  );
    return cdb[CDB_VALID] && (tag != '0) &&
           (cdb[CDB_TAG_HI:CDB_TAG_LO] == tag);
  endfunction

  function automatic val_t cdb_val(
    input logic [CDBW-1:0] cdb
  );
    return cdb[CDB_VAL_HI:CDB_VAL_LO];
  endfunction

endpackage

// File: rtl/reg_status_file.sv
// Register status table: per-register value V and producer tag Qi.
// Ports: 2 async read ports, rename write (ren_*), CDB snoop; r0 reads 0.
module reg_status_file
  import tomasulo_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  output logic [TAGW-1:0] q1,
  output logic [XLEN-1:0] v1,
  output logic [TAGW-1:0] q2,
  output logic [XLEN-1:0] v2,
  input  logic            ren_we,
  input  logic [4:0]      ren_rd,
  input  logic [TAGW-1:0] ren_tag,
  input  logic [CDBW-1:0] cdb
);

  tag_t qi [NREGS];
  val_t v  [NREGS];

  always_comb begin
    q1 = '0;
    v1 = '0;
    q2 = '0;
    v2 = '0;
    if (rs1 != 5'd0) begin
      q1 = qi[rs1];
      v1 = v[rs1];
    end
    if (rs2 != 5'd0) begin
      q2 = qi[rs2];
      v2 = v[rs2];
    end
  end

  // Rename is applied after the snoop so a same-cycle rename wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREGS; r++) begin
        qi[r] <= '0;
        v[r]  <= '0;
      end
    end else begin
      for (int r = 1; r < NREGS; r++) begin
        if (cdb_hit(cdb, qi[r])) begin
          qi[r] <= '0;
          v[r]  <= cdb_val(cdb);
        end
      end
      if (ren_we && ren_rd != 5'd0)
        qi[ren_rd] <= ren_tag;
    end
  end

endmodule

// File: rtl/issue_rename_stage.sv
// Issue/rename: reads Qi/V, renames rd to the unit RS tag, issues one pulse.
// Ports: dec_* in, unit_busy/unit_tag/cdb in, issue_out/q*/v* out.
// Macro RENAME_BYPASS_EN: CDB forward at decode and at issue.
module issue_rename_stage
  import tomasulo_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              dec_valid,
  output logic              dec_ready,
  input  logic [1:0]        dec_unit,
  input  logic [4:0]        dec_rs1,
  input  logic [4:0]        dec_rs2,
  input  logic [4:0]        dec_rd,
  input  logic              dec_rd_we,
  input  logic [3:0]        unit_busy,
  input  logic [4*TAGW-1:0] unit_tag,
  input  logic [CDBW-1:0]   cdb,
  output logic [3:0]        issue_out,
  output logic [TAGW-1:0]   q1_out,
  output logic [TAGW-1:0]   q2_out,
  output logic [XLEN-1:0]   v1_out,
  output logic [XLEN-1:0]   v2_out
);

  tag_t       rq1, rq2, sq1, sq2;
  val_t       rv1, rv2, sv1, sv2;
  tag_t       dec_tag;
  logic       hold, fire, accept;
  logic       dec_stall, late1, late2;
  logic [1:0] held_unit;
  opnd_t      held;

  assign dec_tag = unit_tag[dec_unit*TAGW +: TAGW];

  reg_status_file u_rsf (
    .clk     (clk),
    .rst     (rst),
    .rs1     (dec_rs1),
    .rs2     (dec_rs2),
    .q1      (rq1),
    .v1      (rv1),
    .q2      (rq2),
    .v2      (rv2),
    .ren_we  (accept && dec_rd_we),
    .ren_rd  (dec_rd),
    .ren_tag (dec_tag),
    .cdb     (cdb)
  );

  always_comb begin
    sq1 = rq1;
    sv1 = rv1;
    sq2 = rq2;
    sv2 = rv2;
`ifdef RENAME_BYPASS_EN
    dec_stall = 1'b0;
    if (cdb_hit(cdb, rq1)) begin
      sq1 = '0;
      sv1 = cdb_val(cdb);
    end
    if (cdb_hit(cdb, rq2)) begin
      sq2 = '0;
      sv2 = cdb_val(cdb);
    end
`else
    // The table clears this tag on the edge; retry next cycle.
    dec_stall = cdb_hit(cdb, rq1) || cdb_hit(cdb, rq2);
`endif
  end

  assign late1 = hold && cdb_hit(cdb, held.q1);
  assign late2 = hold && cdb_hit(cdb, held.q2);

  always_comb begin
    q1_out = held.q1;
    v1_out = held.v1;
    q2_out = held.q2;
    v2_out = held.v2;
`ifdef RENAME_BYPASS_EN
    fire = hold;
    if (late1) begin
      q1_out = '0;
      v1_out = cdb_val(cdb);
    end
    if (late2) begin
      q2_out = '0;
      v2_out = cdb_val(cdb);
    end
`else
    // Hold one cycle; the snoop below captures the value.
    fire = hold && !late1 && !late2;
`endif
    issue_out = fire ? (4'b0001 << held_unit) : 4'b0000;
  end

  // A held op blocks its own unit: that unit's tag is stale.
  assign dec_ready = !unit_busy[dec_unit] && !dec_stall &&
                     (!hold || (fire && held_unit != dec_unit));
  assign accept = dec_valid && dec_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold      <= 1'b0;
      held_unit <= UNIT_ALU;
      held      <= '0;
    end else if (accept) begin
      hold      <= 1'b1;
      held_unit <= dec_unit;
      held      <= '{q1: sq1, v1: sv1, q2: sq2, v2: sv2};
    end else begin
      if (fire)
        hold <= 1'b0;
      if (late1) begin
        held.q1 <= '0;
        held.v1 <= cdb_val(cdb);
      end
      if (late2) begin
        held.q2 <= '0;
        held.v2 <= cdb_val(cdb);
      end
    end
  end

endmodule
